// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, load-size codes, write-back FSM
// states and the context a pending load carries while waiting for memory.
package cpu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    LS_BYTE = 2'd0,
    LS_HALF = 2'd1,
    LS_WORD = 2'd2,
    LS_ILL  = 2'd3
  } load_size_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [4:0] rd;
    logic       wen;
    load_size_e size;
    logic       uns;
    logic [1:0] addr_lo;
  } load_ctx_t;

  // A load is dropped when its address does not fit its size, or the size
  // code is the reserved one.
  function automatic logic load_misaligned(input load_size_e size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      LS_BYTE: mis = 1'b0;
      LS_HALF: mis = addr_lo[0];
      LS_WORD: mis = (addr_lo != 2'd0);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of an aligned load word and extends it
// to XLEN bits, zero- or sign-extended as the instruction asks.
module load_align
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] i_rdata,
  input  load_size_e      i_size,
  input  logic            i_unsigned,
  input  logic [1:0]      i_addr_lo,
  output logic [XLEN-1:0] o_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_bsign;
  logic        w_hsign;

  assign w_byte  = 8'(i_rdata >> {i_addr_lo, 3'b000});
  assign w_half  = 16'(i_rdata >> {i_addr_lo[1], 4'b0000});
  assign w_bsign = ~i_unsigned & w_byte[7];
  assign w_hsign = ~i_unsigned & w_half[15];

  // Size-dependent selection and extension.
  always_comb begin
    o_value = i_rdata;
    case (i_size)
      LS_BYTE: o_value = {{(XLEN-8){w_bsign}}, w_byte};
      LS_HALF: o_value = {{(XLEN-16){w_hsign}}, w_half};
      default: o_value = i_rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires ALU results immediately and waits for load data
// (with a timeout) before writing the register file. One write per cycle.
module wb_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic [4:0]      ex_rd_addr_i,
  input  logic            ex_rd_wen_i,
  input  logic [XLEN-1:0] ex_result_i,
  input  logic            ex_load_i,
  input  logic [1:0]      ex_load_size_i,
  input  logic            ex_load_unsigned_i,
  input  logic [1:0]      ex_addr_lo_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic [4:0]      reg_waddr_o,
  output logic [XLEN-1:0] reg_wdata_o,
  output logic            reg_wen_o,
  output logic            busy_o,
  output logic            err_misalign_o,
  output logic            err_timeout_o
);

  // Last counter value before the stage gives up on the load.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  wb_state_e       r_state;
  load_ctx_t       r_ctx;
  logic [7:0]      r_cnt;
  logic            w_accept;
  load_size_e      w_size;
  logic [XLEN-1:0] w_load_val;

  assign ex_ready_o = (r_state == ST_IDLE);
  assign busy_o     = (r_state == ST_WAIT_MEM);
  assign w_accept   = ex_valid_i && ex_ready_o;
  assign w_size     = load_size_e'(ex_load_size_i);

  load_align u_align (
    .i_rdata   (mem_rdata_i),
    .i_size    (r_ctx.size),
    .i_unsigned(r_ctx.uns),
    .i_addr_lo (r_ctx.addr_lo),
    .o_value   (w_load_val)
  );

  // FSM with registered write-port and error outputs; pulses default low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_ctx          <= '0;
      r_cnt          <= '0;
      reg_waddr_o    <= '0;
      reg_wdata_o    <= '0;
      reg_wen_o      <= 1'b0;
      err_misalign_o <= 1'b0;
      err_timeout_o  <= 1'b0;
    end else begin
      reg_wen_o      <= 1'b0;
      err_misalign_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (!ex_load_i) begin
              reg_waddr_o <= ex_rd_addr_i;
              reg_wdata_o <= ex_result_i;
              reg_wen_o   <= ex_rd_wen_i && (ex_rd_addr_i != 5'd0);
            end else if (load_misaligned(w_size, ex_addr_lo_i)) begin
              err_misalign_o <= 1'b1;
            end else begin
              r_ctx.rd      <= ex_rd_addr_i;
              r_ctx.wen     <= ex_rd_wen_i;
              r_ctx.size    <= w_size;
              r_ctx.uns     <= ex_load_unsigned_i;
              r_ctx.addr_lo <= ex_addr_lo_i;
              r_cnt         <= '0;
              r_state       <= ST_WAIT_MEM;
            end
          end
        end
        ST_WAIT_MEM: begin
          // Data arriving on the last allowed cycle still wins over timeout.
          if (mem_rvalid_i) begin
            reg_waddr_o <= r_ctx.rd;
            reg_wdata_o <= w_load_val;
            reg_wen_o   <= r_ctx.wen && (r_ctx.rd != 5'd0);
            r_state     <= ST_IDLE;
          end else if (r_cnt == TO_LAST) begin
            err_timeout_o <= 1'b1;
            r_state       <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Randomized scoreboard bench for wb_stage. The driver pushes expected
// register writes / misalign pulses; a negedge monitor pops and compares.
module tb_wb_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [4:0]  ex_rd_addr_i;
  logic        ex_rd_wen_i;
  logic [31:0] ex_result_i;
  logic        ex_load_i;
  logic [1:0]  ex_load_size_i;
  logic        ex_load_unsigned_i;
  logic [1:0]  ex_addr_lo_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic        reg_wen_o;
  logic        busy_o;
  logic        err_misalign_o;
  logic        err_timeout_o;

  wb_stage #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_wen_i(ex_rd_wen_i),
    .ex_result_i(ex_result_i), .ex_load_i(ex_load_i),
    .ex_load_size_i(ex_load_size_i), .ex_load_unsigned_i(ex_load_unsigned_i),
    .ex_addr_lo_i(ex_addr_lo_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .reg_waddr_o(reg_waddr_o),
    .reg_wdata_o(reg_wdata_o), .reg_wen_o(reg_wen_o), .busy_o(busy_o),
    .err_misalign_o(err_misalign_o), .err_timeout_o(err_timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_err;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   exp_to  = 1'b0;

  // Reference: the loaded value by plain arithmetic on the word.
  function automatic logic [31:0] ref_load(logic [31:0] w, int size, bit uns, int lo);
    longint v;
    case (size)
      0: begin v = (w >> (8 * lo)) & 255;          if (!uns && v >= 128)   v -= 256;   end
      1: begin v = (w >> (16 * (lo / 2))) & 65535; if (!uns && v >= 32768) v -= 65536; end
      default: v = w;
    endcase
    return v[31:0];
  endfunction

  function automatic bit ref_mis(int size, int lo);
    return (size == 3) || (size == 1 && (lo % 2) == 1) || (size == 2 && lo != 0);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write or misalign pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (reg_wen_o === 1'b1 || err_misalign_o === 1'b1) begin
      n_tests++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: wen=%b mis=%b addr=%0d data=%h (t=%0t)",
                 reg_wen_o, err_misalign_o, reg_waddr_o, reg_wdata_o, $time);
      end else begin
        e = sbq.pop_front();
        if (e.is_err) begin
          if (!(err_misalign_o === 1'b1 && reg_wen_o === 1'b0)) begin
            n_fail++;
            $display("FAIL misalign_evt: got wen=%b mis=%b, expected misalign pulse only (t=%0t)",
                     reg_wen_o, err_misalign_o, $time);
          end
        end else if (!(reg_wen_o === 1'b1 && err_misalign_o === 1'b0 &&
                       reg_waddr_o === e.addr && reg_wdata_o === e.data)) begin
          n_fail++;
          $display("FAIL write_evt: got wen=%b mis=%b x%0d=%h, expected x%0d=%h (t=%0t)",
                   reg_wen_o, err_misalign_o, reg_waddr_o, reg_wdata_o, e.addr, e.data, $time);
        end
      end
    end
  end

  task automatic alu(logic [4:0] rd, bit wen, logic [31:0] res);
    chk("ready_alu", ex_ready_o, 1);
    chk("timeout_sticky", err_timeout_o, exp_to);
    ex_valid_i = 1; ex_load_i = 0; ex_rd_addr_i = rd; ex_rd_wen_i = wen;
    ex_result_i = res; ex_load_size_i = 2'($urandom); ex_addr_lo_i = 2'($urandom);
    if (wen && rd != 0) sbq.push_back('{1'b0, rd, res});
    tick();
  endtask

  task automatic load(logic [4:0] rd, bit wen, int size, bit uns, int lo,
                      logic [31:0] rdata, int d, bit hold);
    chk("ready_load", ex_ready_o, 1);
    chk("timeout_sticky", err_timeout_o, exp_to);
    ex_valid_i = 1; ex_load_i = 1; ex_rd_addr_i = rd; ex_rd_wen_i = wen;
    ex_load_size_i = size[1:0]; ex_load_unsigned_i = uns; ex_addr_lo_i = lo[1:0];
    ex_result_i = $urandom;
    if (ref_mis(size, lo)) begin
      sbq.push_back('{1'b1, 5'd0, 32'd0});
      tick();
      ex_valid_i = 0;
      return;
    end
    tick();
    // While waiting, either idle EX or hold a pending ALU op stable.
    if (hold) begin
      ex_valid_i = 1; ex_load_i = 0; ex_rd_addr_i = 5'd9; ex_rd_wen_i = 1;
      ex_result_i = 32'hCAFE_0009;
    end else ex_valid_i = 0;
    for (int k = 0; k < d && k < TO; k++) begin
      chk("busy_wait", busy_o, 1);
      chk("ready_wait", ex_ready_o, 0);
      mem_rvalid_i = 0; mem_rdata_i = $urandom;
      tick();
    end
    if (d < TO) begin
      chk("busy_data", busy_o, 1);
      if (wen && rd != 0) sbq.push_back('{1'b0, rd, ref_load(rdata, size, uns, lo)});
      mem_rvalid_i = 1; mem_rdata_i = rdata;
      tick();
      mem_rvalid_i = 0;
    end else begin
      exp_to = 1'b1;
      chk("timeout_set", err_timeout_o, 1);
      chk("busy_after_to", busy_o, 0);
      // Late data after the abort must be ignored.
      ex_valid_i = 0;
      mem_rvalid_i = 1; mem_rdata_i = $urandom;
      tick();
      mem_rvalid_i = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0; ex_valid_i = 0; ex_rd_addr_i = 0; ex_rd_wen_i = 0; ex_result_i = 0;
    ex_load_i = 0; ex_load_size_i = 0; ex_load_unsigned_i = 0; ex_addr_lo_i = 0;
    mem_rvalid_i = 0; mem_rdata_i = 0;
    tick(); tick();
    chk("rst_wen", reg_wen_o, 0);
    chk("rst_waddr", reg_waddr_o, 0);
    chk("rst_wdata", reg_wdata_o, 0);
    chk("rst_mis", err_misalign_o, 0);
    chk("rst_to", err_timeout_o, 0);
    chk("rst_ready", ex_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    rst = 1;
    tick();

    // ALU write, then quiet cycle.
    alu(5'd5, 1, 32'h1234_5678);
    ex_valid_i = 0; tick(); tick();
    // Signed byte load with an ALU op held stable during the wait.
    load(5'd3, 1, 0, 0, 2, 32'h0080_0000, 2, 1);
    alu(5'd9, 1, 32'hCAFE_0009);
    load(5'd3, 1, 0, 1, 2, 32'h0080_0000, 2, 0);
    // Misaligned word and illegal size.
    load(5'd4, 1, 2, 0, 1, 32'h0, 0, 0);
    load(5'd4, 1, 3, 0, 0, 32'h0, 0, 0);
    // Data on the very last wait cycle wins over timeout.
    load(5'd8, 1, 1, 0, 2, 32'h8001_7FFF, TO - 1, 0);
    // x0 followed by x7, back-to-back.
    alu(5'd0, 1, 32'hDEAD_BEEF);
    alu(5'd7, 1, 32'h0000_0777);
    // Timeout, late data ignored.
    load(5'd6, 1, 2, 0, 0, 32'h0, TO + 1, 0);
    ex_valid_i = 0; tick();

    // Reset mid-load: pending load discarded, sticky timeout cleared.
    chk("to_before_rst", err_timeout_o, 1);
    ex_valid_i = 1; ex_load_i = 1; ex_rd_addr_i = 5'd12; ex_rd_wen_i = 1;
    ex_load_size_i = 2; ex_addr_lo_i = 0;
    tick();
    ex_valid_i = 0;
    chk("busy_pre_rst", busy_o, 1);
    #2 rst = 0;
    #1;
    exp_to = 1'b0;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_to", err_timeout_o, 0);
    chk("mid_rst_wen", reg_wen_o, 0);
    chk("mid_rst_waddr", reg_waddr_o, 0);
    chk("mid_rst_wdata", reg_wdata_o, 0);
    #1 rst = 1;
    tick();
    mem_rvalid_i = 1; mem_rdata_i = 32'h5555_AAAA;
    tick();
    mem_rvalid_i = 0;
    tick();
    chk("post_rst_ready", ex_ready_o, 1);

    // Random mix.
    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 4)
        alu(5'($urandom), 1'($urandom_range(0, 3) != 0), $urandom);
      else if (kind < 9)
        load(5'($urandom), 1'($urandom_range(0, 3) != 0), $urandom_range(0, 3),
             1'($urandom), $urandom_range(0, 3), $urandom, $urandom_range(0, TO + 1), 0);
      else begin
        ex_valid_i = 0;
        mem_rvalid_i = 1'($urandom); mem_rdata_i = $urandom;
        tick();
        mem_rvalid_i = 0;
      end
    end

    ex_valid_i = 0;
    tick(); tick(); tick();
    chk("final_to", err_timeout_o, exp_to);
    chk("sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYC, 255, max cycles waiting for load data before abort (1..255).
REQ-002 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: ex_valid_i  in  1  EX result present this cycle.
REQ-005 SHALL have port: ex_ready_o  out  1  stage can accept EX result.
REQ-006 SHALL have port: ex_rd_addr_i  in  5  destination register.
REQ-007 SHALL have port: ex_rd_wen_i  in  1  instruction writes rd.
REQ-008 SHALL have port: ex_result_i  in  32  ALU result (non-load).
REQ-009 SHALL have port: ex_load_i  in  1  instruction is a load.
REQ-010 SHALL have port: ex_load_size_i  in  2  0 byte, 1 half, 2 word, 3 illegal.
REQ-011 SHALL have port: ex_load_unsigned_i  in  1  zero-extend instead of sign-extend.
REQ-012 SHALL have port: ex_addr_lo_i  in  2  load address bits [1:0].
REQ-013 SHALL have port: mem_rvalid_i  in  1  load data valid.
REQ-014 SHALL have port: mem_rdata_i  in  32  aligned load word.
REQ-015 SHALL have port: reg_waddr_o  out  5  register-file write address.
REQ-016 SHALL have port: reg_wdata_o  out  32  register-file write data.
REQ-017 SHALL have port: reg_wen_o  out  1  register-file write enable, one-cycle pulse.
REQ-018 SHALL have port: busy_o  out  1  load outstanding (for hazard/stall logic).
REQ-019 SHALL have port: err_misalign_o  out  1  one-cycle pulse, misaligned/illegal load dropped.
REQ-020 SHALL have port: err_timeout_o  out  1  sticky, load data never arrived.

Function
REQ-021 SHALL implement FSM states IDLE, WAIT_MEM; ex_ready_o = (state==IDLE), busy_o = (state==WAIT_MEM).
REQ-022 SHALL accept a transfer only when ex_valid_i && ex_ready_o.
REQ-023 Non-load accept: reg_waddr_o/reg_wdata_o = rd/ex_result_i, reg_wen_o = ex_rd_wen_i && rd!=0, registered, visible the cycle after accept (latency 1).
REQ-024 Load accept: SHALL capture rd, wen, size, unsigned, addr_lo, clear timeout counter, enter WAIT_MEM; misaligned (half at addr_lo odd, word at addr_lo!=0, size 3) SHALL instead pulse err_misalign_o next cycle, write nothing, stay IDLE.
REQ-025 In WAIT_MEM with mem_rvalid_i: select byte mem_rdata_i[8*addr_lo+:8] or half [16*addr_lo[1]+:16] or word, extend per unsigned flag to 32 bits, write next cycle per REQ-023 rules, return IDLE.
REQ-026 In WAIT_MEM without mem_rvalid_i: counter increments; at count == TIMEOUT_CYC-1 SHALL set err_timeout_o, drop the write, return IDLE.
REQ-027 mem_rvalid_i in IDLE SHALL be ignored (no write, no error).
REQ-028 ex_valid_i in WAIT_MEM SHALL not be accepted; EX holds its inputs stable until ready.
REQ-029 mem_rvalid_i and timeout in the same cycle: data SHALL win, no error.
REQ-030 reg_wen_o SHALL be 0 in every cycle not following a completed write; writes to x0 never assert it.
REQ-031 A new accept in the cycle the previous write is on outputs SHALL be legal (back-to-back, one write per cycle).

Reset
REQ-032 On rst low, asynchronously: state IDLE, counter 0, reg_waddr_o 0, reg_wdata_o 0, reg_wen_o 0, err_misalign_o 0, err_timeout_o 0.
REQ-033 Reset during WAIT_MEM SHALL discard the pending load; no write after release.
REQ-034 err_timeout_o SHALL clear only by reset.

Structure
REQ-035 Load-size codes, FSM state encoding and XLEN=32 SHALL live in shared package cpu_pkg.
REQ-036 Byte/half selection and extension SHALL be one combinational sub-module load_align (inputs rdata, size, unsigned, addr_lo; output 32-bit value).

Verification
REQ-037 ALU write: accept rd=5, result 0x1234_5678 -> next cycle reg_wen_o=1, waddr 5, wdata 0x1234_5678; following cycle reg_wen_o=0.
REQ-038 Signed byte load: rd=3, size 0, addr_lo 2, mem_rdata 0x0080_0000 after 3 cycles -> ex_ready_o low 3 cycles, then write 0xFFFF_FF80 to x3; unsigned variant -> 0x0000_0080.
REQ-039 Misaligned: word load addr_lo 1 -> err_misalign_o pulse, no reg_wen_o, ex_ready_o stays 1.
REQ-040 Timeout: TIMEOUT_CYC=4, load with no mem_rvalid_i -> err_timeout_o set after 4 wait cycles, state IDLE, no write; mem_rvalid_i afterwards ignored.
REQ-041 Reset mid-load: rst low during WAIT_MEM, then mem_rvalid_i after release -> no write, all outputs 0.
REQ-042 x0 and back-to-back: ALU to rd=0 then ALU to rd=7 consecutive cycles -> no write for x0, write to x7 one cycle later.
